// File: rtl/uart_pkg.sv
// uart_pkg - definitions shared by the UART transmitter and receiver.
//   uartState_t    : FSM state encodings (fixed values, the receiver uses them too)
//   TIMER_W        : width of the per-bit baud timer
//   bitTicks()     : system clocks per bit, integer truncation
//   halfBitTicks() : system clocks per half bit (receiver mid-bit sampling)
package uart_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        STOP_BIT   = 3'd3,
        PARITY_BIT = 3'd4
    } uartState_t;

    function automatic int bitTicks(input int sysClock, input int baudRate);
        return sysClock / baudRate;
    endfunction

    function automatic int halfBitTicks(input int sysClock, input int baudRate);
        return bitTicks(sysClock, baudRate) / 2;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// uart_baud_timer - counts 0..BIT_TICKS-1 while enabled and flags the last count.
//   i_SysClock : system clock
//   i_ResetN   : asynchronous active-low reset
//   enable     : count this cycle
//   restart    : hold the count at zero (takes priority over enable)
//   tick       : high on the last count of each bit period
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int BIT_TICKS = 434
) (
    input  logic i_SysClock,
    input  logic i_ResetN,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(BIT_TICKS - 1);
    localparam logic [TIMER_W-1:0] ONE  = TIMER_W'(1);

    logic [TIMER_W-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN)
            count <= '0;
        else if (restart)
            count <= '0;
        else if (enable)
            count <= tick ? '0 : count + ONE;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx - byte-wide valid/ready in, LSB-first async serial frame out.
//   i_SysClock : system clock, rising edge
//   i_ResetN   : asynchronous active-low reset
//   i_TxValid  : producer has a byte on i_TxByte
//   i_TxByte   : byte to send, latched on accept
//   o_TxReady  : byte accepted this cycle if i_TxValid
//   o_TxSerial : serial line (registered, idles high)
//   o_TxDone   : one-cycle pulse in the last stop-bit cycle
// Build option: define UART_TX_PARITY_EN for a parity bit (even, or odd when
// PARITY_ODD = 1); without it the frame is 8N1.
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int PARITY_ODD    = 0
) (
    input  logic       i_SysClock,
    input  logic       i_ResetN,
    input  logic       i_TxValid,
    input  logic [7:0] i_TxByte,
    output logic       o_TxReady,
    output logic       o_TxSerial,
    output logic       o_TxDone
);

    localparam int BIT_TICKS = bitTicks(SYS_CLOCK, UART_BAUDRATE);

    uartState_t state, stateNext;
    logic [7:0] shiftReg, shiftNext;
    logic [2:0] bitCnt, bitCntNext;
    logic       serialNext;
    logic       tick;
    logic       accept;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte at accept time since the shifter consumes it.
    logic parityBit, parityNext;
`else
    // Parity sense has no effect in the 8N1 build.
    localparam bit unusedParityOdd = (PARITY_ODD != 0);
`endif

    // Ready in IDLE and in the final stop-bit cycle so frames can chain with no gap.
    assign o_TxReady = (state == IDLE) || ((state == STOP_BIT) && tick);
    assign o_TxDone  = (state == STOP_BIT) && tick;
    assign accept    = i_TxValid && o_TxReady;

    uart_baud_timer #(.BIT_TICKS(BIT_TICKS)) u_baudTimer (
        .i_SysClock (i_SysClock),
        .i_ResetN   (i_ResetN),
        .enable     (state != IDLE),
        .restart    (state == IDLE),
        .tick       (tick)
    );

    always_comb begin
        stateNext  = state;
        shiftNext  = shiftReg;
        bitCntNext = bitCnt;
`ifdef UART_TX_PARITY_EN
        parityNext = parityBit;
`endif
        case (state)
            IDLE: ;
            START_BIT:
                if (tick) stateNext = DATA_BITS;
            DATA_BITS:
                if (tick) begin
                    shiftNext  = shiftReg >> 1;
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        stateNext = PARITY_BIT;
`else
                        stateNext = STOP_BIT;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT:
                if (tick) stateNext = STOP_BIT;
`endif
            STOP_BIT:
                if (tick) stateNext = IDLE;
            default:
                stateNext = IDLE;
        endcase

        // Accept can only happen in IDLE or the last stop cycle; both load a new frame.
        if (accept) begin
            stateNext  = START_BIT;
            shiftNext  = i_TxByte;
            bitCntNext = '0;
`ifdef UART_TX_PARITY_EN
            parityNext = (^i_TxByte) ^ (PARITY_ODD != 0);
`endif
        end

        // Line value is derived from the next state so the register lines up with it.
        case (stateNext)
            START_BIT:  serialNext = 1'b0;
            DATA_BITS:  serialNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: serialNext = parityNext;
`endif
            default:    serialNext = 1'b1;
        endcase
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state      <= IDLE;
            shiftReg   <= '0;
            bitCnt     <= '0;
            o_TxSerial <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parityBit  <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            shiftReg   <= shiftNext;
            bitCnt     <= bitCntNext;
            o_TxSerial <= serialNext;
`ifdef UART_TX_PARITY_EN
            parityBit  <= parityNext;
`endif
        end
    end

endmodule
